// File: rtl/wb_reg_pkg.sv
`default_nettype none
// ============================================================
// Module : wb_reg_pkg
// Brief  : Shared offsets, STATUS bit positions and FSM states
// Rev    : 1.0
// ============================================================
package wb_reg_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] OFF_REG0   = 4'd0;
    localparam logic [3:0] OFF_REG1   = 4'd1;
    localparam logic [3:0] OFF_REG2   = 4'd2;
    localparam logic [3:0] OFF_REG3   = 4'd3;
    localparam logic [3:0] OFF_ID     = 4'd4;
    localparam logic [3:0] OFF_STATUS = 4'd5;
    localparam logic [3:0] OFF_FIFO   = 4'd6;

    localparam int STAT_EMPTY_BIT = 4;
    localparam int STAT_FULL_BIT  = 5;
    localparam int STAT_OVF_BIT   = 6;
    localparam int STAT_UDF_BIT   = 7;

    localparam int FIFO_DEPTH  = 8;
    localparam int NUM_RW_REGS = 4;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with combinational first-word read
// Rev    : 1.0
// ============================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    // Requests against a full/empty FIFO are dropped here; the caller flags them.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_reg_responder.sv
`default_nettype none
// ============================================================
// Module : wb_reg_responder
// Brief  : Wishbone register slave with RW regs, ID, STATUS, FIFO
// Rev    : 1.0
// ============================================================
module wb_reg_responder #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hBE11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   wbs_address,
    input  logic [DATA_WIDTH-1:0]   wbs_writedata,
    output logic [DATA_WIDTH-1:0]   wbs_readdata,
    input  logic                    wbs_write,
    input  logic                    wbs_strobe,
    input  logic                    wbs_cycle,
    output logic                    wbs_ack,
    output logic [4*DATA_WIDTH-1:0] reg_out,
    output logic                    fifo_irq
);
    import wb_reg_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_regs [NUM_RW_REGS];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_sel;
    logic                  w_accept;
    logic [3:0]            w_offset;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic [DATA_WIDTH-1:0] w_fifo_rdata;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_unused;

    assign w_unused    = wbs_cycle;
    assign w_sel       = (wbs_address[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign w_offset    = wbs_address[3:0];
    // The single side effect of an access happens only on the IDLE->ACK edge.
    assign w_accept    = (r_state == ST_IDLE) && wbs_strobe && w_sel;
    assign w_fifo_push = w_accept && wbs_write && (w_offset == OFF_FIFO);
    assign w_fifo_pop  = w_accept && !wbs_write && (w_offset == OFF_FIFO);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .wdata (wbs_writedata),
        .rdata (w_fifo_rdata),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (wbs_strobe && w_sel) w_next_state = ST_ACK;
            ST_ACK:  w_next_state = ST_HOLD;
            ST_HOLD: if (!wbs_strobe) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack  = (r_state == ST_ACK);
        fifo_irq = !w_fifo_empty;
    end

    always_comb begin
        w_status                 = '0;
        w_status[CNT_W-1:0]      = w_fifo_count;
        w_status[STAT_EMPTY_BIT] = w_fifo_empty;
        w_status[STAT_FULL_BIT]  = w_fifo_full;
        w_status[STAT_OVF_BIT]   = r_ovf;
        w_status[STAT_UDF_BIT]   = r_udf;
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_offset)
            OFF_REG0, OFF_REG1, OFF_REG2, OFF_REG3: w_rd_mux = r_regs[w_offset[1:0]];
            OFF_ID:     w_rd_mux = ID_VALUE;
            OFF_STATUS: w_rd_mux = w_status;
            OFF_FIFO:   w_rd_mux = w_fifo_empty ? '0 : w_fifo_rdata;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs  <= '{default: '0};
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (w_accept) begin
            if (wbs_write) begin
                case (w_offset)
                    OFF_REG0, OFF_REG1, OFF_REG2, OFF_REG3:
                        r_regs[w_offset[1:0]] <= wbs_writedata;
                    OFF_STATUS: begin
                        if (wbs_writedata[STAT_OVF_BIT]) r_ovf <= 1'b0;
                        if (wbs_writedata[STAT_UDF_BIT]) r_udf <= 1'b0;
                    end
                    OFF_FIFO: if (w_fifo_full) r_ovf <= 1'b1;
                    default: ;
                endcase
            end else begin
                r_rdata <= w_rd_mux;
                if ((w_offset == OFF_FIFO) && w_fifo_empty) r_udf <= 1'b1;
            end
        end else if ((r_state == ST_IDLE) && wbs_strobe && !w_sel) begin
            r_rdata <= '0;
        end
    end

    assign wbs_readdata = r_rdata;

    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_regout
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_reg_responder.sv
`default_nettype none
// ============================================================
// Module : tb_wb_reg_responder
// Brief  : Directed + random bench with a queue-based register model
// Rev    : 1.0
// ============================================================
`timescale 1ns/1ps
module tb_wb_reg_responder;

    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] wbs_address;
    logic [15:0] wbs_writedata;
    logic [15:0] wbs_readdata;
    logic        wbs_write;
    logic        wbs_strobe;
    logic        wbs_cycle;
    logic        wbs_ack;
    logic [63:0] reg_out;
    logic        fifo_irq;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_regs [4];
    logic [15:0] m_q [$];
    bit          m_ovf;
    bit          m_udf;
    logic [15:0] m_rdata;

    always #5 clk = ~clk;

    wb_reg_responder dut (
        .clk           (clk),
        .reset         (reset),
        .wbs_address   (wbs_address),
        .wbs_writedata (wbs_writedata),
        .wbs_readdata  (wbs_readdata),
        .wbs_write     (wbs_write),
        .wbs_strobe    (wbs_strobe),
        .wbs_cycle     (wbs_cycle),
        .wbs_ack       (wbs_ack),
        .reg_out       (reg_out),
        .fifo_irq      (fifo_irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_q.delete();
        m_ovf   = 0;
        m_udf   = 0;
        m_rdata = '0;
    endtask

    function automatic logic [15:0] m_status();
        logic [15:0] s;
        s      = '0;
        s[3:0] = 4'(m_q.size());
        s[4]   = (m_q.size() == 0);
        s[5]   = (m_q.size() == 8);
        s[6]   = m_ovf;
        s[7]   = m_udf;
        return s;
    endfunction

    task automatic model_step(input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                              output bit ack, output logic [15:0] rd);
        int off;
        off = int'(addr[3:0]);
        rd  = '0;
        if (addr[15:4] != BASE[15:4]) begin
            ack     = 0;
            m_rdata = '0;
            return;
        end
        ack = 1;
        if (wr) begin
            if (off < 4) m_regs[off] = wd;
            else if (off == 5) begin
                if (wd[6]) m_ovf = 0;
                if (wd[7]) m_udf = 0;
            end else if (off == 6) begin
                if (m_q.size() == 8) m_ovf = 1;
                else m_q.push_back(wd);
            end
        end else begin
            if (off < 4) rd = m_regs[off];
            else if (off == 4) rd = 16'hBE11;
            else if (off == 5) rd = m_status();
            else if (off == 6) begin
                if (m_q.size() == 0) begin
                    rd    = '0;
                    m_udf = 1;
                end else rd = m_q.pop_front();
            end
            m_rdata = rd;
        end
    endtask

    // Hold strobe for 'hold' cycles, recording every ack seen and when.
    task automatic drive(input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                         input int hold, output logic [15:0] rd, output int acks, output int ack_at);
        @(negedge clk);
        wbs_address   = addr;
        wbs_write     = wr;
        wbs_writedata = wd;
        wbs_strobe    = 1'b1;
        wbs_cycle     = 1'b1;
        acks   = 0;
        ack_at = -1;
        rd     = '0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (wbs_ack === 1'b1) begin
                acks++;
                if (ack_at < 0) ack_at = i;
                rd = wbs_readdata;
            end
        end
        wbs_strobe = 1'b0;
        wbs_cycle  = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] addr, input logic wr,
                       input logic [15:0] wd, input int hold, output logic [15:0] got);
        bit          eack;
        logic [15:0] erd;
        logic [15:0] rd;
        int          acks;
        int          ack_at;
        model_step(addr, wr, wd, eack, erd);
        drive(addr, wr, wd, hold, rd, acks, ack_at);
        chk({tag, ":acks"}, 64'(acks), eack ? 64'd1 : 64'd0);
        if (eack) chk({tag, ":ack_lat"}, 64'(ack_at), 64'd1);
        if (eack && !wr) chk({tag, ":rd_at_ack"}, 64'(rd), 64'(erd));
        chk({tag, ":rd_held"}, 64'(wbs_readdata), 64'(m_rdata));
        chk({tag, ":reg_out"}, reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        chk({tag, ":irq"}, 64'(fifo_irq), 64'(m_q.size() != 0));
        got = rd;
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] addr;
        int          acks;
        int          ack_at;
        int          r;
        bit          eack;
        logic [15:0] erd;

        reset = 1'b1;
        wbs_address = '0; wbs_writedata = '0; wbs_write = 1'b0;
        wbs_strobe = 1'b0; wbs_cycle = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst:ack", 64'(wbs_ack), 64'd0);
        chk("rst:rdata", 64'(wbs_readdata), 64'd0);
        chk("rst:reg_out", reg_out, 64'd0);
        chk("rst:irq", 64'(fifo_irq), 64'd0);
        reset = 1'b0;

        run("wr_reg2", 16'h0002, 1'b1, 16'hA5A5, 10, got);
        chk("wr_reg2:field", 64'(reg_out[47:32]), 64'hA5A5);

        run("rd_id", 16'h0004, 1'b0, '0, 4, got);
        chk("rd_id:val", 64'(got), 64'hBE11);
        repeat (3) @(negedge clk);
        chk("rd_id:held", 64'(wbs_readdata), 64'hBE11);

        for (int i = 1; i <= 9; i++) run("push", 16'h0006, 1'b1, 16'(i), 2, got);
        run("st_full", 16'h0005, 1'b0, '0, 2, got);
        chk("st_full:val", 64'(got), 64'h0068);
        for (int i = 1; i <= 8; i++) begin
            run("pop", 16'h0006, 1'b0, '0, 3, got);
            chk("pop:val", 64'(got), 64'(i));
        end
        chk("pop:irq_last", 64'(fifo_irq), 64'd0);

        run("pop_empty", 16'h0006, 1'b0, '0, 2, got);
        chk("pop_empty:val", 64'(got), 64'd0);
        run("st_udf", 16'h0005, 1'b0, '0, 2, got);
        chk("st_udf:bit7", 64'(got[7]), 64'd1);
        run("w1c", 16'h0005, 1'b1, 16'h00C0, 2, got);
        run("st_clr", 16'h0005, 1'b0, '0, 2, got);
        chk("st_clr:val", 64'(got), 64'h0010);

        run("unsel", BASE + 16'h0010, 1'b1, 16'hFFFF, 6, got);
        chk("unsel:rdata", 64'(wbs_readdata), 64'd0);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            addr = (r <= 6) ? 16'(r) : 16'($urandom_range(7, 15));
            if ($urandom_range(0, 7) == 0) addr = addr | 16'($urandom_range(1, 4095) << 4);
            run("rand", addr, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(2, 5), got);
        end

        // Reset landing in HOLD must abort; a strobe still high afterwards is a new access.
        run("pre_rst", 16'h0000, 1'b1, 16'hFFFF, 2, got);
        @(negedge clk);
        wbs_address = 16'h0006; wbs_write = 1'b1; wbs_writedata = 16'h1234;
        wbs_strobe = 1'b1; wbs_cycle = 1'b1;
        model_step(16'h0006, 1'b1, 16'h1234, eack, erd);
        @(negedge clk);
        chk("mid:ack", 64'(wbs_ack), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        chk("mid_rst:ack", 64'(wbs_ack), 64'd0);
        chk("mid_rst:irq", 64'(fifo_irq), 64'd0);
        chk("mid_rst:reg_out", reg_out, 64'd0);
        reset = 1'b0;
        model_step(16'h0006, 1'b1, 16'h1234, eack, erd);
        acks = 0;
        ack_at = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (wbs_ack === 1'b1) begin
                acks++;
                if (ack_at < 0) ack_at = i;
            end
        end
        chk("post_rst:acks", 64'(acks), 64'd1);
        chk("post_rst:lat", 64'(ack_at), 64'd1);
        wbs_strobe = 1'b0; wbs_cycle = 1'b0;
        run("post_rst_st", 16'h0005, 1'b0, '0, 2, got);
        chk("post_rst_st:val", 64'(got), 64'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_reg_responder.md
WB_REG_RESPONDER -- requirements
Module: wb_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: Wishbone data width.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0000: block base address; bits [3:0] are ignored.
REQ-004 SHALL have parameter ID_VALUE, default 16'hBE11: constant returned at offset 4.
REQ-005 SHALL have port clk  in  1: the only clock, rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset, sampled on clk.
REQ-007 SHALL have port wbs_address  in  ADDR_WIDTH: access address.
REQ-008 SHALL have port wbs_writedata  in  DATA_WIDTH: write data.
REQ-009 SHALL have port wbs_readdata  out  DATA_WIDTH: registered read data.
REQ-010 SHALL have port wbs_write  in  1: high = write, low = read.
REQ-011 SHALL have port wbs_strobe  in  1: access request, level-held by the initiator for many cycles.
REQ-012 SHALL have port wbs_cycle  in  1: accepted but not required to start an access.
REQ-013 SHALL have port wbs_ack  out  1: single-cycle acknowledge.
REQ-014 SHALL have port reg_out  out  4*DATA_WIDTH: RW registers 0..3, reg N at bits [N*16+15:N*16].
REQ-015 SHALL have port fifo_irq  out  1: high while the loopback FIFO is non-empty.

Function
REQ-016 SHALL select the block when wbs_address[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]; offset = wbs_address[3:0].
REQ-017 SHALL implement FSM IDLE -> ACK -> HOLD -> IDLE.
REQ-018 In IDLE, a cycle with wbs_strobe=1 and the block selected SHALL move to ACK and perform exactly one side effect.
REQ-019 In IDLE, an unselected strobe SHALL cause no ack, no side effect, and wbs_readdata=0.
REQ-020 In ACK, wbs_ack SHALL be 1 for exactly one cycle, then the FSM SHALL move to HOLD; ack latency is one cycle after strobe is sampled.
REQ-021 In HOLD, the FSM SHALL stay until wbs_strobe=0, then return to IDLE; no repeat side effect while strobe stays high.
REQ-022 On reads, wbs_readdata SHALL be loaded at the IDLE->ACK transition and held stable until the next read is accepted.
REQ-023 Register map, offsets 0-3: RW registers driving reg_out.
REQ-024 Register map, offset 4: ID_VALUE, read-only.
REQ-025 Register map, offset 5: STATUS, bits [3:0] count, [4] empty, [5] full, [6] overflow sticky, [7] underflow sticky, other bits 0.
REQ-026 Register map, offset 6: FIFO port; a write pushes, a read pops.
REQ-027 Register map, offsets 7-15: reads return 0 and writes are ignored, but the access is still acknowledged.
REQ-028 Writing STATUS SHALL clear overflow when wbs_writedata[6]=1 and clear underflow when wbs_writedata[7]=1 (W1C); other bits are read-only.
REQ-029 The FIFO SHALL be 8 entries x DATA_WIDTH; count SHALL range 0..8, with pointers wrapping modulo 8.
REQ-030 A push when full SHALL drop the data, leave count unchanged, and set overflow.
REQ-031 A pop when empty SHALL return 0, leave count unchanged, and set underflow.
REQ-032 Popped data SHALL be the oldest entry, returned in the same ack as its read (first-word visible, no extra latency).
REQ-033 fifo_irq SHALL equal !empty, registered with the count.

Reset
REQ-034 On reset=1 at a clk edge: FSM=IDLE, wbs_ack=0, wbs_readdata=0, reg_out=0, FIFO pointers/count=0, overflow=underflow=0, fifo_irq=0.
REQ-035 Reset asserted mid-access (in ACK or HOLD) SHALL abort the access; a still-high strobe after reset releases SHALL count as a new access.

Structure
REQ-036 Register offsets, STATUS bit positions and FSM state encodings SHALL live in a shared package wb_reg_pkg.
REQ-037 The FIFO SHALL be a sub-module sync_fifo (parameters DEPTH=8, WIDTH=DATA_WIDTH) with push, pop, rdata, count, full and empty ports.

Verification
REQ-038 Write 16'hA5A5 to offset 2, strobe held 10 cycles -> one ack, 1 cycle after strobe; reg_out[47:32]=16'hA5A5.
REQ-039 Read offset 4 -> wbs_readdata=16'hBE11 with ack and held after strobe drops.
REQ-040 Push 1..9 to offset 6 -> STATUS=16'h0068 (count 8, full, overflow); then 8 pops return 1..8, fifo_irq=0 after the last pop.
REQ-041 Pop while empty -> readdata 0, STATUS[7]=1; write STATUS 16'h00C0 -> STATUS=16'h0010.
REQ-042 Strobe to address BASE_ADDR+16'h0010 -> no ack, no register change.
REQ-043 Assert reset during HOLD after a push -> ack=0, count=0, reg_out=0; a strobe held through reset release triggers one new ack.
